// File: rtl/debounce_multi_if.sv
// Button-side bundle for debounce_multi: raw inputs in, filtered levels and strobes out.
// The master drives the raw buttons; the debouncer is the slave.
interface debounce_multi_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] noisy;
  logic [CHANNELS-1:0] debounced;
  logic [CHANNELS-1:0] press_pulse;
  logic [CHANNELS-1:0] release_pulse;
  logic [CHANNELS-1:0] hold;
  logic [CHANNELS-1:0] hold_pulse;

  modport master (
    output noisy,
    input  debounced, press_pulse, release_pulse, hold, hold_pulse
  );

  modport slave (
    input  noisy,
    output debounced, press_pulse, release_pulse, hold, hold_pulse
  );
endinterface

// File: rtl/debounce_multi.sv
// Multi-channel push-button debouncer: per channel a 2-flop synchroniser, a four-state
// stability FSM, registered press/release strobes and an optional long-press detector.
module debounce_multi #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 500000,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int ACTIVE_LOW    = 0
) (
  input logic             clk,
  input logic             reset_n,
  debounce_multi_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARM_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    ARM_RELEASE = 2'd3
  } state_e;

  localparam int             CNT_W   = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic           INVERT  = (ACTIVE_LOW != 0);

  logic [CHANNELS-1:0] debounced_v;
  logic [CHANNELS-1:0] press_v;
  logic [CHANNELS-1:0] release_v;
  logic [CHANNELS-1:0] hold_v;
  logic [CHANNELS-1:0] hold_pulse_v;

  assign bus.debounced     = debounced_v;
  assign bus.press_pulse   = press_v;
  assign bus.release_pulse = release_v;
  assign bus.hold          = hold_v;
  assign bus.hold_pulse    = hold_pulse_v;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [1:0]       sync_q, sync_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             debounced_q, debounced_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             s;

    // Synchroniser resets to the raw inactive level so that s reads 0 in reset.
    assign s = sync_q[1] ^ INVERT;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_q      <= {2{INVERT}};
        state_q     <= IDLE;
        cnt_q       <= '0;
        debounced_q <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
      end else begin
        sync_q      <= sync_d;
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        debounced_q <= debounced_d;
        press_q     <= press_d;
        release_q   <= release_d;
      end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
      sync_d    = {sync_q[0], bus.noisy[i]};
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (s) state_d = ARM_PRESS;
        end
        ARM_PRESS: begin
          if (!s) begin
            state_d = IDLE;
          end else if (cnt_q == CNT_MAX) begin
            state_d = PRESSED;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          cnt_d = '0;
          if (!s) state_d = ARM_RELEASE;
        end
        ARM_RELEASE: begin
          if (s) begin
            state_d = PRESSED;
          end else if (cnt_q == CNT_MAX) begin
            state_d   = IDLE;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
      debounced_d = (state_d == PRESSED) || (state_d == ARM_RELEASE);
    end

    assign debounced_v[i] = debounced_q;
    assign press_v[i]     = press_q;
    assign release_v[i]   = release_q;

    if (HOLD_CYCLES == 0) begin : g_no_hold
      assign hold_v[i]       = 1'b0;
      assign hold_pulse_v[i] = 1'b0;
    end else begin : g_hold
      localparam int          HW       = $clog2(HOLD_CYCLES + 1);
      localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

      logic [HW-1:0] hcnt_q, hcnt_d;
      logic          hold_q, hold_d;
      logic          hold_pulse_q, hold_pulse_d;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          hcnt_q       <= '0;
          hold_q       <= 1'b0;
          hold_pulse_q <= 1'b0;
        end else begin
          hcnt_q       <= hcnt_d;
          hold_q       <= hold_d;
          hold_pulse_q <= hold_pulse_d;
        end
      end

      // Clearing on the next-state level lets hold drop on the same edge as debounced;
      // counting on the current level puts the rise HOLD_CYCLES edges after debounced.
      always_comb begin
        hcnt_d = hcnt_q;
        if (!debounced_d) begin
          hcnt_d = '0;
        end else if (debounced_q && (hcnt_q != HOLD_MAX)) begin
          hcnt_d = hcnt_q + 1'b1;
        end
        hold_d       = (hcnt_d == HOLD_MAX);
        hold_pulse_d = (hcnt_d == HOLD_MAX) && (hcnt_q != HOLD_MAX);
      end

      assign hold_v[i]       = hold_q;
      assign hold_pulse_v[i] = hold_pulse_q;
    end
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboarded bench for debounce_multi: three instances (plain, hold-enabled, active-low);
// stimulus queues expected strobes with their edge numbers, a negedge monitor pops and compares.
module tb_debounce_multi;
  localparam int SC  = 8;
  localparam int LAT = SC + 3;  // drive at a negedge -> strobe seen at the negedge LAT edges later
  localparam int HC  = 20;

  typedef enum int {K_PRESS = 0, K_RELEASE = 1, K_HOLD = 2} kind_e;
  typedef struct {
    int    dut;
    kind_e kind;
    int    ch;
    int    cyc;
  } ev_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   edge_n  = 0;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  ev_t  exp_q[$];

  debounce_multi_if #(.CHANNELS(2)) a_if ();
  debounce_multi_if #(.CHANNELS(2)) h_if ();
  debounce_multi_if #(.CHANNELS(4)) l_if ();

  debounce_multi #(.CHANNELS(2), .STABLE_CYCLES(SC), .HOLD_CYCLES(0), .ACTIVE_LOW(0))
    dut_a (.clk(clk), .reset_n(reset_n), .bus(a_if));
  debounce_multi #(.CHANNELS(2), .STABLE_CYCLES(SC), .HOLD_CYCLES(HC), .ACTIVE_LOW(0))
    dut_h (.clk(clk), .reset_n(reset_n), .bus(h_if));
  debounce_multi #(.CHANNELS(4), .STABLE_CYCLES(SC), .HOLD_CYCLES(0), .ACTIVE_LOW(1))
    dut_l (.clk(clk), .reset_n(reset_n), .bus(l_if));

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %h, expected %h", name, edge_n, act, exp_v);
    end
  endtask

  task automatic expect_ev(input int d, input kind_e k, input int c, input int cyc);
    ev_t e;
    e.dut = d; e.kind = k; e.ch = c; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int d, input kind_e k, input int c, input logic lvl);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_strobe: got dut%0d kind%0d ch%0d at edge %0d, expected none",
               d, k, c, edge_n);
    end else begin
      e = exp_q.pop_front();
      if (e.dut != d || e.kind != k || e.ch != c || e.cyc != edge_n || lvl !== (k != K_RELEASE)) begin
        n_bad++;
        $display("FAIL strobe: got dut%0d kind%0d ch%0d edge %0d level %b, expected dut%0d kind%0d ch%0d edge %0d",
                 d, k, c, edge_n, lvl, e.dut, e.kind, e.ch, e.cyc);
      end
    end
  endtask

  // Monitor: any strobe must match the head of the expected queue.
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (a_if.press_pulse[c])   observe(0, K_PRESS,   c, a_if.debounced[c]);
      if (a_if.release_pulse[c]) observe(0, K_RELEASE, c, a_if.debounced[c]);
      if (a_if.hold_pulse[c])    observe(0, K_HOLD,    c, a_if.hold[c]);
    end
    for (int c = 0; c < 2; c++) begin
      if (h_if.press_pulse[c])   observe(1, K_PRESS,   c, h_if.debounced[c]);
      if (h_if.release_pulse[c]) observe(1, K_RELEASE, c, h_if.debounced[c]);
      if (h_if.hold_pulse[c])    observe(1, K_HOLD,    c, h_if.hold[c]);
    end
    for (int c = 0; c < 4; c++) begin
      if (l_if.press_pulse[c])   observe(2, K_PRESS,   c, l_if.debounced[c]);
      if (l_if.release_pulse[c]) observe(2, K_RELEASE, c, l_if.debounced[c]);
      if (l_if.hold_pulse[c])    observe(2, K_HOLD,    c, l_if.hold[c]);
    end
  end

  task automatic wait_until(input int t);
    while (edge_n < t) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    a_if.noisy = '0;
    h_if.noisy = '0;
    l_if.noisy = '1;
    idle(3);
    check("reset_a", {a_if.debounced, a_if.press_pulse, a_if.release_pulse, a_if.hold, a_if.hold_pulse}, '0);
    check("reset_h", {h_if.debounced, h_if.press_pulse, h_if.release_pulse, h_if.hold, h_if.hold_pulse}, '0);
    check("reset_l", {l_if.debounced, l_if.press_pulse, l_if.release_pulse, l_if.hold, l_if.hold_pulse}, '0);
    reset_n = 1'b1;
    idle(20);
    check("active_low_idle", {l_if.debounced, l_if.hold}, '0);
    check("plain_idle", a_if.debounced, '0);

    // Clean press and release on channel 0.
    t = edge_n; a_if.noisy = 2'b01; expect_ev(0, K_PRESS, 0, t + LAT);
    wait_until(t + LAT - 1); check("a_pre_press", a_if.debounced, 2'b00);
    wait_until(t + LAT);     check("a_press_level", a_if.debounced, 2'b01);
    wait_until(t + LAT + 1); check("a_press_width", a_if.press_pulse, 2'b00);
    idle(5);
    t = edge_n; a_if.noisy = 2'b00; expect_ev(0, K_RELEASE, 0, t + LAT);
    wait_until(t + LAT - 1); check("a_pre_release", a_if.debounced, 2'b01);
    wait_until(t + LAT);     check("a_release_level", a_if.debounced, 2'b00);
    idle(5);

    // Bounce every 3 cycles, then a clean final rise.
    for (int i = 0; i < 14; i++) begin
      a_if.noisy = (i % 2 == 0) ? 2'b01 : 2'b00;
      idle(3);
    end
    check("a_bounce_level", a_if.debounced, 2'b00);
    t = edge_n; a_if.noisy = 2'b01; expect_ev(0, K_PRESS, 0, t + LAT);
    wait_until(t + LAT + 2);

    // Short low glitch while pressed must not release.
    a_if.noisy = 2'b00; idle(4); a_if.noisy = 2'b01;
    for (int i = 0; i < 4; i++) begin
      idle(3);
      check("a_glitch_level", a_if.debounced, 2'b01);
    end
    t = edge_n; a_if.noisy = 2'b00; expect_ev(0, K_RELEASE, 0, t + LAT);
    wait_until(t + LAT + 2);

    // Two channels strobing in the same cycle.
    t = edge_n; a_if.noisy = 2'b11;
    expect_ev(0, K_PRESS, 0, t + LAT); expect_ev(0, K_PRESS, 1, t + LAT);
    wait_until(t + LAT); check("a_dual_press", a_if.debounced, 2'b11);
    idle(3);
    t = edge_n; a_if.noisy = 2'b00;
    expect_ev(0, K_RELEASE, 0, t + LAT); expect_ev(0, K_RELEASE, 1, t + LAT);
    wait_until(t + LAT + 2);

    // Hold on channel 1, with a release bounce while the hold counter runs.
    t = edge_n; h_if.noisy = 2'b10;
    expect_ev(1, K_PRESS, 1, t + LAT); expect_ev(1, K_HOLD, 1, t + LAT + HC);
    wait_until(t + LAT + 3); h_if.noisy = 2'b00; idle(3); h_if.noisy = 2'b10;
    wait_until(t + LAT + HC - 1); check("h_hold_early", h_if.hold, 2'b00);
    wait_until(t + LAT + HC);     check("h_hold_level", h_if.hold, 2'b10);
    idle(10); check("h_hold_saturated", h_if.hold, 2'b10);
    t = edge_n; h_if.noisy = 2'b00; expect_ev(1, K_RELEASE, 1, t + LAT);
    wait_until(t + LAT - 1); check("h_hold_before_release", {h_if.hold, h_if.debounced}, 4'b1010);
    wait_until(t + LAT);     check("h_hold_drop", {h_if.hold, h_if.debounced}, 4'b0000);
    idle(3);

    // Active-low channel 3.
    t = edge_n; l_if.noisy = 4'b0111; expect_ev(2, K_PRESS, 3, t + LAT);
    wait_until(t + LAT); check("l_press_level", l_if.debounced, 4'b1000);
    idle(3);
    t = edge_n; l_if.noisy = 4'b1111; expect_ev(2, K_RELEASE, 3, t + LAT);
    wait_until(t + LAT + 2); check("l_release_level", l_if.debounced, 4'b0000);

    // Asynchronous reset mid-press, then a fresh debounce with the button still held.
    t = edge_n; a_if.noisy = 2'b01; expect_ev(0, K_PRESS, 0, t + LAT);
    wait_until(t + LAT + 3);
    #2 reset_n = 1'b0;
    #1 check("a_async_reset", {a_if.debounced, a_if.press_pulse, a_if.release_pulse}, '0);
    idle(2);
    reset_n = 1'b1;
    t = edge_n; expect_ev(0, K_PRESS, 0, t + LAT);
    wait_until(t + LAT - 1); check("a_after_reset_pre", a_if.debounced, 2'b00);
    wait_until(t + LAT);     check("a_after_reset_press", a_if.debounced, 2'b01);
    idle(3);
    t = edge_n; a_if.noisy = 2'b00; expect_ev(0, K_RELEASE, 0, t + LAT);
    wait_until(t + LAT + 3);

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
